// File: rtl/selector_pkg.sv
// Shared constants for the selector decimation link.
// Tx and rx sides must agree on the frame period.
package selector_pkg;

   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] VERIFY = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam int PERIOD_DEF    = 3;
   localparam int LOCK_GOOD_DEF = 2;
   localparam int LOCK_BAD_DEF  = 2;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fase_counter.sv
// Modulo-PERIOD frame phase counter.
// Priority: clear, anchor load-to-1, hold, count.
module fase_counter #(
   parameter int PERIOD = 3,
   parameter int PW     = 2
) (
   input  logic          clk,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic          hold_i,
   output logic [PW-1:0] fase_o,
   output logic          at_zero_o
);

   localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] fase_q, fase_d;

   always_comb begin
      fase_d = fase_q;
      if (clr_i)
         fase_d = '0;
      else if (load_i)
         fase_d = ONE;
      else if (hold_i)
         fase_d = fase_q;
      else if (fase_q == LAST)
         fase_d = '0;
      else
         fase_d = fase_q + ONE;
   end

   always_ff @(posedge clk) begin
      fase_q <= fase_d;
   end

   assign fase_o    = fase_q;
   assign at_zero_o = (fase_q == '0);

endmodule

// File: rtl/selector_sync.sv
// Recovers frame timing from a decimated selector line
// and re-samples it on the recovered frame boundary.
module selector_sync
   import selector_pkg::*;
#(
   parameter  int PERIOD    = PERIOD_DEF,
   parameter  int LOCK_GOOD = LOCK_GOOD_DEF,
   parameter  int LOCK_BAD  = LOCK_BAD_DEF,
   localparam int PW        = max_i(1, $clog2(PERIOD))
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          selector_atrasado,
   output logic          selector_recuperado,
   output logic [PW-1:0] fase,
   output logic          frame_start,
   output logic          locked,
   output logic          error
);

   localparam int CMX = max_i(LOCK_GOOD, LOCK_BAD);
   localparam int CW  = $clog2(CMX + 1);
   localparam logic [CW-1:0] CMAX   = CW'(CMX);
   localparam logic [CW-1:0] GOOD_N = CW'(LOCK_GOOD);
   localparam logic [CW-1:0] BAD_N  = CW'(LOCK_BAD);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] good_q, good_d, good_inc;
   logic [CW-1:0] bad_q, bad_d, bad_inc;
   logic          sel_q, edge_s, at_zero;
   logic          anchor, unlock, to_lock, ld_sel;
   logic          rec_q, rec_d, fs_q, lk_q;
   logic          err_q, err_d;

   assign edge_s   = (selector_atrasado != sel_q);
   assign good_inc = (good_q == CMAX) ? good_q
                                      : good_q + CW'(1);
   assign bad_inc  = (bad_q == CMAX) ? bad_q
                                     : bad_q + CW'(1);

   fase_counter #(
      .PERIOD (PERIOD),
      .PW     (PW)
   ) u_fase (
      .clk       (clk),
      .clr_i     (reset | unlock),
      .load_i    (anchor),
      .hold_i    (state_q == SEARCH),
      .fase_o    (fase),
      .at_zero_o (at_zero)
   );

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      anchor  = 1'b0;
      unlock  = 1'b0;
      to_lock = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         SEARCH: begin
            if (edge_s) begin
               anchor  = 1'b1;
               good_d  = '0;
               state_d = VERIFY;
            end
         end
         VERIFY: begin
            if (edge_s && at_zero) begin
               good_d = good_inc;
               if (good_inc >= GOOD_N) begin
                  to_lock = 1'b1;
                  bad_d   = '0;
                  state_d = LOCKED;
               end
            end else if (edge_s) begin
               anchor = 1'b1;
               good_d = '0;
            end
         end
         LOCKED: begin
            if (edge_s && at_zero) begin
               bad_d = '0;
            end else if (edge_s) begin
               err_d = 1'b1;
               bad_d = bad_inc;
               // Unlocking edge is dropped, not reused as anchor
               if (bad_inc >= BAD_N) begin
                  unlock  = 1'b1;
                  good_d  = '0;
                  bad_d   = '0;
                  state_d = SEARCH;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   assign ld_sel = at_zero & ((state_q == LOCKED) | to_lock);
   assign rec_d  = ld_sel ? selector_atrasado : rec_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEARCH;
         good_q  <= '0;
         bad_q   <= '0;
         sel_q   <= 1'b0;
         rec_q   <= 1'b0;
         fs_q    <= 1'b0;
         lk_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         sel_q   <= selector_atrasado;
         rec_q   <= rec_d;
         fs_q    <= ld_sel;
         lk_q    <= (state_d == LOCKED);
         err_q   <= err_d;
      end
   end

   assign selector_recuperado = rec_q;
   assign frame_start         = fs_q;
   assign locked              = lk_q;
   assign error               = err_q;

endmodule
